booth_mul_seq: RTL and testbench

//  Sequential controller for the radix-4 Booth multiply path of the arithmetic unit.
//  It latches signed operands on a start pulse and recodes one Booth triplet per cycle.

---
 rtl/booth_mul_seq.sv | 90 +++++++++
 tb/tb_booth_mul_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier: one recoded triplet per RUN cycle into a
// 2*WIDTH accumulator, registered signed product presented with a one-cycle done.
module booth_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH / 2) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH:0]   bx;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    pp_sh;

  assign busy = (state == S_RUN) || (state == S_DONE);

  // bx shifts right two bits per cycle, so the current triplet is always bx[2:0]
  always_comb begin
    a_ext = {{WIDTH{mcand[WIDTH-1]}}, mcand};
    case (bx[2:0])
      3'b001, 3'b010: pp = a_ext;
      3'b011:         pp = a_ext << 1;
      3'b100:         pp = -(a_ext << 1);
      3'b101, 3'b110: pp = -a_ext;
      default:        pp = '0;
    endcase
    pp_sh = pp << {cnt, 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      mcand  <= '0;
      bx     <= '0;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= a;
            bx    <= {b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            acc <= acc + pp_sh;
            bx  <= {2'b00, bx[WIDTH:2]};
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= S_DONE;
          end
        end
        S_DONE: begin
          result <= acc;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq at WIDTH=8 and WIDTH=16.
module tb_booth_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, abort = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        busy, done;
  logic [15:0] result;

  logic        start16 = 1'b0, abort16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [31:0] result16;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [15:0] sb[$];
  logic [31:0] sb16[$];

  booth_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  booth_mul_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .abort(abort16),
    .a(a16), .b(b16), .busy(busy16), .done(done16), .result(result16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] prod8(input logic [7:0] x, input logic [7:0] y);
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[15:0];
  endfunction

  function automatic logic [31:0] prod16(input logic [15:0] x, input logic [15:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[31:0];
  endfunction

  // One full multiply on the 8-bit instance: accept, scramble operands, wait for done.
  task automatic do_op8(input logic [7:0] x, input logic [7:0] y);
    int n;
    logic [15:0] exp;
    a = x; b = y; start = 1'b1;
    sb.push_back(prod8(x, y));
    step();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom);
    total++;
    if (busy !== 1'b1) $display("FAIL op8_busy: busy=%b required 1", busy); else passed++;
    n = 0;
    while (done !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (n !== 5) $display("FAIL op8_latency: %0d cycles required 5", n); else passed++;
    exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    total++;
    if (result !== exp)
      $display("FAIL op8_result: a=%0d b=%0d result=%h required %h", $signed(x), $signed(y), result, exp);
    else passed++;
    total++;
    if (busy !== 1'b0) $display("FAIL op8_busy_done: busy=%b required 0", busy); else passed++;
  endtask

  task automatic do_op16(input logic [15:0] x, input logic [15:0] y);
    int n;
    logic [31:0] exp;
    a16 = x; b16 = y; start16 = 1'b1;
    sb16.push_back(prod16(x, y));
    step();
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom);
    n = 0;
    while (done16 !== 1'b1 && n < 30) begin step(); n++; end
    total++;
    if (n !== 9) $display("FAIL op16_latency: %0d cycles required 9", n); else passed++;
    exp = (sb16.size() > 0) ? sb16.pop_front() : 32'hxxxxxxxx;
    total++;
    if (result16 !== exp)
      $display("FAIL op16_result: a=%0d b=%0d result=%h required %h", $signed(x), $signed(y), result16, exp);
    else passed++;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({busy, done, result} !== 18'd0)
      $display("FAIL reset8: busy=%b done=%b result=%h required 0", busy, done, result);
    else passed++;
    total++;
    if ({busy16, done16, result16} !== 34'd0)
      $display("FAIL reset16: busy=%b done=%b result=%h required 0", busy16, done16, result16);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // 3*5 with starts of other operands pulsed while busy; they must leave no trace.
  task automatic test_basic();
    int n;
    int extra;
    a = 8'd3; b = 8'd5; start = 1'b1;
    sb.push_back(prod8(8'd3, 8'd5));
    step();
    a = 8'd100; b = 8'd100; start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      start = (n == 1 || n == 3 || n == 4);
      total++;
      if (busy !== 1'b1) $display("FAIL basic_busy: cycle %0d busy=%b required 1", n, busy); else passed++;
      step(); n++;
    end
    start = 1'b0;
    total++;
    if (n !== 5) $display("FAIL basic_latency: %0d cycles required 5", n); else passed++;
    total++;
    if (result !== sb.pop_front()) $display("FAIL basic_result: result=%h required 000f", result); else passed++;
    extra = 0;
    for (int i = 0; i < 10; i++) begin step(); if (done === 1'b1 || busy === 1'b1) extra++; end
    total++;
    if (extra !== 0) $display("FAIL basic_ignored_start: %0d busy/done cycles required 0", extra); else passed++;
  endtask

  task automatic test_corners();
    do_op8(8'h80, 8'h80);
    do_op8(8'h80, 8'h7F);
    do_op8(8'h7F, 8'h7F);
    do_op8(8'hFF, 8'hFF);
    do_op8(8'h00, 8'h95);
    do_op8(8'h55, 8'hAA);
    do_op16(16'h8000, 16'h8000);
    do_op16(16'h8000, 16'h7FFF);
  endtask

  task automatic test_back_to_back();
    int n;
    int gap;
    a = 8'd7; b = 8'hFE; start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(prod8(8'd7, 8'hFE));
    for (int k = 0; k < 3; k++) begin
      n = 0;
      step(); n++;
      while (done !== 1'b1 && n < 20) begin step(); n++; end
      if (k == 2) start = 1'b0;
      total++;
      if (result !== sb.pop_front()) $display("FAIL b2b_result: result=%h required fff2", result); else passed++;
      gap = n;
      if (k > 0) begin
        total++;
        if (gap !== 6) $display("FAIL b2b_period: %0d cycles required 6", gap); else passed++;
      end
    end
    step();
    total++;
    if (busy !== 1'b0) $display("FAIL b2b_idle: busy=%b required 0", busy); else passed++;
  endtask

  task automatic test_abort();
    int pulses;
    int n;
    do_op8(8'd3, 8'd5);
    a = 8'd9; b = 8'd9; start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (busy !== 1'b0) $display("FAIL abort_busy: busy=%b required 0", busy); else passed++;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin step(); if (done === 1'b1) pulses++; end
    total++;
    if (pulses !== 0) $display("FAIL abort_done: %0d pulses required 0", pulses); else passed++;
    total++;
    if (result !== 16'd15) $display("FAIL abort_result: result=%h required 000f", result); else passed++;

    // start and abort together in IDLE: start wins
    a = 8'd2; b = 8'd3; start = 1'b1; abort = 1'b1;
    sb.push_back(prod8(8'd2, 8'd3));
    step();
    start = 1'b0; abort = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 20) begin step(); n++; end
    total++;
    if (n !== 5 || result !== sb.pop_front())
      $display("FAIL abort_idle: latency=%0d result=%h required 5/0006", n, result);
    else passed++;

    // abort during DONE does not cancel the pulse
    a = 8'hFD; b = 8'd4; start = 1'b1;
    sb.push_back(prod8(8'hFD, 8'd4));
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if (done !== 1'b1 || result !== sb.pop_front())
      $display("FAIL abort_in_done: done=%b result=%h required 1/fff4", done, result);
    else passed++;
  endtask

  task automatic test_reset_mid();
    a = 8'd5; b = 8'd6; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, result} !== 18'd0)
      $display("FAIL reset_mid: busy=%b done=%b result=%h required 0", busy, done, result);
    else passed++;
    step();
    rst_n = 1'b1;
    step();
    do_op8(8'hF9, 8'd11);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) do_op8(8'($urandom), 8'($urandom));
    for (int i = 0; i < 300; i++) do_op16(16'($urandom), 16'($urandom));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
